// File: rtl/axi4_sram_responder.sv
// AXI4 responder backed by a flop-based word memory.
// Write and read sides run as two independent FSMs sharing only the array.
//
//   state  | meaning
//   W_IDLE | waiting for AW; aw_ready high
//   W_DATA | accepting W beats; w_ready high
//   W_RESP | presenting B until b_ready
//   R_IDLE | waiting for AR; ar_ready high
//   R_DATA | presenting R beats; next beat loads on each r_ready handshake
module axi4_sram_responder #(
  parameter int DEPTH = 256,
  parameter int ID_W  = 6
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            aw_valid,
  output logic            aw_ready,
  input  logic [ID_W-1:0] aw_id,
  input  logic [31:0]     aw_addr,
  input  logic [7:0]      aw_len,
  input  logic [2:0]      aw_size,
  input  logic [1:0]      aw_burst,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [31:0]     w_data,
  input  logic [3:0]      w_strb,
  input  logic            w_last,
  output logic            b_valid,
  input  logic            b_ready,
  output logic [ID_W-1:0] b_id,
  output logic [1:0]      b_resp,
  input  logic            ar_valid,
  output logic            ar_ready,
  input  logic [ID_W-1:0] ar_id,
  input  logic [31:0]     ar_addr,
  input  logic [7:0]      ar_len,
  input  logic [2:0]      ar_size,
  input  logic [1:0]      ar_burst,
  output logic            r_valid,
  input  logic            r_ready,
  output logic [ID_W-1:0] r_id,
  output logic [31:0]     r_data,
  output logic [1:0]      r_resp,
  output logic            r_last
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [31:0] mem [DEPTH];
  logic        live;

  logic [1:0]      w_state;
  logic [ID_W-1:0] w_id_q;
  logic [31:0]     w_addr_q;
  logic [7:0]      w_len_q;
  logic [7:0]      w_cnt_q;
  logic            w_fixed_q;
  logic            w_bad_q;
  logic            w_slverr_q;
  logic            w_decerr_q;

  logic [0:0]      r_state;
  logic [ID_W-1:0] r_id_q;
  logic [31:0]     r_addr_q;
  logic [7:0]      r_len_q;
  logic [7:0]      r_cnt_q;
  logic            r_fixed_q;
  logic            r_bad_q;
  logic [31:0]     r_data_q;
  logic [1:0]      r_resp_q;
  logic            r_last_q;

  // ready stays low while reset is held so every output reads 0 in reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) live <= 1'b0;
    else          live <= 1'b1;
  end

  logic w_fire, w_beat_dec, w_beat_last, w_write_en;
  logic [AW-1:0] w_idx;

  assign aw_ready    = live && (w_state == W_IDLE);
  assign w_ready     = (w_state == W_DATA);
  assign b_valid     = (w_state == W_RESP);
  assign b_id        = w_id_q;
  assign b_resp      = w_slverr_q ? RESP_SLVERR : (w_decerr_q ? RESP_DECERR : RESP_OKAY);
  assign w_fire      = w_valid && w_ready;
  assign w_beat_dec  = (w_addr_q[31:2] >= 30'(DEPTH));
  assign w_beat_last = (w_cnt_q == w_len_q);
  assign w_write_en  = w_fire && !w_bad_q && !w_beat_dec;
  assign w_idx       = w_addr_q[AW+1:2];

  // write FSM: latch the burst on AW, walk beats, hold B until accepted
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_state    <= W_IDLE;
      w_id_q     <= '0;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_cnt_q    <= '0;
      w_fixed_q  <= 1'b0;
      w_bad_q    <= 1'b0;
      w_slverr_q <= 1'b0;
      w_decerr_q <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_valid && aw_ready) begin
            w_id_q     <= aw_id;
            w_addr_q   <= aw_addr;
            w_len_q    <= aw_len;
            w_cnt_q    <= '0;
            w_fixed_q  <= (aw_burst == 2'b00);
            w_bad_q    <= (aw_size != 3'd2) || aw_burst[1];
            w_slverr_q <= (aw_size != 3'd2) || aw_burst[1];
            w_decerr_q <= 1'b0;
            w_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (!w_fixed_q) w_addr_q <= w_addr_q + 32'd4;
            w_cnt_q <= w_cnt_q + 8'd1;
            if (w_beat_dec) w_decerr_q <= 1'b1;
            // beat count alone ends the burst; a disagreeing w_last only taints B
            if (w_last != w_beat_last) w_slverr_q <= 1'b1;
            if (w_beat_last) w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (b_ready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // byte-masked memory write; contents are not reset
  always_ff @(posedge clock) begin
    if (w_write_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  logic [31:0]   r_load_addr;
  logic          r_load_bad;
  logic          r_load_dec;
  logic [AW-1:0] r_load_idx;
  logic [31:0]   r_load_data;
  logic [1:0]    r_load_resp;

  // address, data and response of the beat being loaded this cycle
  always_comb begin
    r_load_addr = ar_addr;
    r_load_bad  = (ar_size != 3'd2) || ar_burst[1];
    if (r_state == R_DATA) begin
      r_load_addr = r_fixed_q ? r_addr_q : r_addr_q + 32'd4;
      r_load_bad  = r_bad_q;
    end
    r_load_dec  = (r_load_addr[31:2] >= 30'(DEPTH));
    r_load_idx  = r_load_addr[AW+1:2];
    r_load_data = (r_load_bad || r_load_dec) ? 32'd0 : mem[r_load_idx];
    r_load_resp = r_load_bad ? RESP_SLVERR : (r_load_dec ? RESP_DECERR : RESP_OKAY);
  end

  assign ar_ready = live && (r_state == R_IDLE);
  assign r_valid  = (r_state == R_DATA);
  assign r_id     = r_id_q;
  assign r_data   = r_data_q;
  assign r_resp   = r_resp_q;
  assign r_last   = r_last_q;

  // read FSM: beat 0 loads on the AR handshake, later beats on each R handshake
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_fixed_q <= 1'b0;
      r_bad_q   <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= '0;
      r_last_q  <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_valid && ar_ready) begin
            r_id_q    <= ar_id;
            r_len_q   <= ar_len;
            r_cnt_q   <= '0;
            r_fixed_q <= (ar_burst == 2'b00);
            r_bad_q   <= r_load_bad;
            r_addr_q  <= r_load_addr;
            r_data_q  <= r_load_data;
            r_resp_q  <= r_load_resp;
            r_last_q  <= (ar_len == 8'd0);
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_ready) begin
            if (r_last_q) begin
              r_last_q <= 1'b0;
              r_state  <= R_IDLE;
            end else begin
              r_addr_q <= r_load_addr;
              r_cnt_q  <= r_cnt_q + 8'd1;
              r_data_q <= r_load_data;
              r_resp_q <= r_load_resp;
              r_last_q <= ((r_cnt_q + 8'd1) == r_len_q);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_sram_responder.sv
// Randomised self-checking bench for axi4_sram_responder against a word-array model.
module tb_axi4_sram_responder;
  localparam int DEPTH = 256;
  localparam int ID_W  = 6;

  logic clock, reset_n;
  logic aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [ID_W-1:0] aw_id, b_id, ar_id, r_id;
  logic [31:0] aw_addr, ar_addr, w_data, r_data;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic [3:0]  w_strb;

  axi4_sram_responder #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  int          flip_last = -1;
  logic [ID_W-1:0] got_bid;
  logic [1:0]      got_bresp;
  logic [31:0]     rd_d [$];
  logic [1:0]      rd_r [$];
  logic            rd_l [$];
  logic [ID_W-1:0] rd_id [$];
  logic            rd_lat_ok;
  int              rd_gaps;
  logic [31:0]     exp_d [$];
  logic [1:0]      exp_r [$];

  // ---------------- reference model ----------------
  function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [1:0] burst, input int i);
    return (burst == 2'b00) ? base : base + 32'(4 * i);
  endfunction

  function automatic bit out_of_range(input logic [31:0] a);
    return (a >> 2) >= 32'(DEPTH);
  endfunction

  function automatic bit unsupported(input logic [2:0] size, input logic [1:0] burst);
    return (size != 3'd2) || (burst > 2'd1);
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input int len,
                                             input logic [2:0] size, input logic [1:0] burst);
    logic [1:0] resp;
    logic [31:0] a;
    int idx;
    resp = 2'b00;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, burst, i);
      if (out_of_range(a)) resp = 2'b11;
      else if (!unsupported(size, burst)) begin
        idx = int'(a >> 2);
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) model_mem[idx][8*b +: 8] = wd[i][8*b +: 8];
      end
    end
    if (unsupported(size, burst)) resp = 2'b10;
    return resp;
  endfunction

  function automatic void model_read(input logic [31:0] addr, input int len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    exp_d.delete();
    exp_r.delete();
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, burst, i);
      if (unsupported(size, burst)) begin exp_d.push_back(32'd0); exp_r.push_back(2'b10); end
      else if (out_of_range(a))     begin exp_d.push_back(32'd0); exp_r.push_back(2'b11); end
      else begin exp_d.push_back(model_mem[int'(a >> 2)]); exp_r.push_back(2'b00); end
    end
  endfunction

  // ---------------- bus drivers ----------------
  task automatic drive_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    int n;
    @(negedge clock);
    aw_valid = 1'b1; aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
    n = 0;
    while (!aw_ready && n < 100) begin @(negedge clock); n++; end
    if (n >= 100) begin checks++; $display("FAIL aw_timeout waited=%0d cycles", n); end
    @(negedge clock);
    aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      w_valid = 1'b1; w_data = wd[i]; w_strb = ws[i];
      w_last = ((i == int'(len)) != (i == flip_last));
      n = 0;
      while (!w_ready && n < 100) begin @(negedge clock); n++; end
      if (n >= 100) begin checks++; $display("FAIL w_timeout beat=%0d", i); end
      @(negedge clock);
    end
    w_valid = 1'b0; w_last = 1'b0;
    n = 0;
    while (!b_valid && n < 100) begin @(negedge clock); n++; end
    if (n >= 100) begin checks++; $display("FAIL b_timeout waited=%0d cycles", n); end
    got_bid = b_id; got_bresp = b_resp;
    b_ready = 1'b1;
    @(negedge clock);
    b_ready = 1'b0;
  endtask

  task automatic drive_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    int n;
    bit done;
    rd_d.delete(); rd_r.delete(); rd_l.delete(); rd_id.delete(); rd_gaps = 0;
    @(negedge clock);
    ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
    n = 0;
    while (!ar_ready && n < 100) begin @(negedge clock); n++; end
    if (n >= 100) begin checks++; $display("FAIL ar_timeout waited=%0d cycles", n); end
    @(negedge clock);
    ar_valid = 1'b0;
    rd_lat_ok = r_valid;
    r_ready = 1'b1;
    done = 1'b0; n = 0;
    while (!done && n < 400) begin
      if (r_valid) begin
        rd_d.push_back(r_data); rd_r.push_back(r_resp); rd_l.push_back(r_last); rd_id.push_back(r_id);
        done = r_last;
      end else rd_gaps++;
      @(negedge clock);
      n++;
    end
    r_ready = 1'b0;
    if (!done) begin checks++; $display("FAIL r_timeout beats=%0d", rd_d.size()); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    aw_valid = 0; w_valid = 0; b_ready = 0; ar_valid = 0; r_ready = 0; w_last = 0;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0;
    w_data = '0; w_strb = '0;
    repeat (3) @(negedge clock);
    checks++;
    if ({aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last, b_resp, r_resp, b_id, r_id, r_data} !== '0)
      $display("FAIL reset_outputs got aw_rdy=%0b w_rdy=%0b b_vld=%0b ar_rdy=%0b r_vld=%0b exp all 0",
               aw_ready, w_ready, b_valid, ar_ready, r_valid);
    else passes++;
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (aw_ready !== 1'b1 || ar_ready !== 1'b1 || w_ready !== 1'b0)
      $display("FAIL reset_release got aw_rdy=%0b ar_rdy=%0b w_rdy=%0b exp 1 1 0", aw_ready, ar_ready, w_ready);
    else passes++;
  endtask

  task automatic test_single();
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF; flip_last = -1;
    drive_write(6'h2A, 32'h10, 8'd0, 3'd2, 2'b01);
    void'(model_write(32'h10, 0, 3'd2, 2'b01));
    checks++;
    if (got_bresp !== 2'b00 || got_bid !== 6'h2A)
      $display("FAIL single_b got resp=%0d id=%0h exp resp=0 id=2a", got_bresp, got_bid);
    else passes++;
    drive_read(6'h15, 32'h10, 8'd0, 3'd2, 2'b01);
    checks++;
    if (rd_d.size() != 1 || rd_d[0] !== 32'hDEADBEEF || rd_r[0] !== 2'b00 || rd_l[0] !== 1'b1 || rd_id[0] !== 6'h15)
      $display("FAIL single_r got n=%0d d=%h resp=%0d last=%0b id=%0h exp n=1 d=deadbeef resp=0 last=1 id=15",
               rd_d.size(), rd_d[0], rd_r[0], rd_l[0], rd_id[0]);
    else passes++;
    checks++;
    if (rd_lat_ok !== 1'b1) $display("FAIL single_rvalid_latency got=%0b exp=1", rd_lat_ok);
    else passes++;
  endtask

  task automatic test_incr_strb();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hFFFFFFFF; ws[i] = 4'hF; end
    drive_write(6'h01, 32'h0, 8'd3, 3'd2, 2'b01);
    void'(model_write(32'h0, 3, 3'd2, 2'b01));
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = (i == 2) ? 4'h3 : 4'hF; end
    drive_write(6'h02, 32'h0, 8'd3, 3'd2, 2'b01);
    checks++;
    if (got_bresp !== model_write(32'h0, 3, 3'd2, 2'b01))
      $display("FAIL incr_bresp got=%0d exp=0", got_bresp);
    else passes++;
    drive_read(6'h03, 32'h0, 8'd3, 3'd2, 2'b01);
    model_read(32'h0, 3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_d.size() <= i || rd_d[i] !== exp_d[i] || rd_r[i] !== exp_r[i] || rd_l[i] !== (i == 3))
        $display("FAIL incr_beat%0d got d=%h resp=%0d exp d=%h resp=%0d", i, rd_d[i], rd_r[i], exp_d[i], exp_r[i]);
      else passes++;
    end
    checks++;
    if (rd_gaps != 0 || rd_d.size() != 4) $display("FAIL incr_b2b got gaps=%0d beats=%0d exp 0 4", rd_gaps, rd_d.size());
    else passes++;
  endtask

  task automatic test_oob();
    logic [31:0] a;
    a = 32'(4 * DEPTH - 4);
    wd[0] = 32'hA5A5_0001; wd[1] = 32'hA5A5_0002; ws[0] = 4'hF; ws[1] = 4'hF;
    drive_write(6'h07, a, 8'd1, 3'd2, 2'b01);
    checks++;
    if (got_bresp !== model_write(a, 1, 3'd2, 2'b01)) $display("FAIL oob_bresp got=%0d exp=3", got_bresp);
    else passes++;
    drive_read(6'h08, a, 8'd1, 3'd2, 2'b01);
    model_read(a, 1, 3'd2, 2'b01);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_d.size() <= i || rd_d[i] !== exp_d[i] || rd_r[i] !== exp_r[i])
        $display("FAIL oob_beat%0d got d=%h resp=%0d exp d=%h resp=%0d", i, rd_d[i], rd_r[i], exp_d[i], exp_r[i]);
      else passes++;
    end
  endtask

  task automatic test_wrap();
    wd[0] = 32'h1111_2222; wd[1] = 32'h3333_4444; ws[0] = 4'hF; ws[1] = 4'hF;
    drive_write(6'h09, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01);
    checks++;
    if (got_bresp !== model_write(32'hFFFF_FFFC, 1, 3'd2, 2'b01)) $display("FAIL wrap_bresp got=%0d exp=3", got_bresp);
    else passes++;
    drive_read(6'h0A, 32'hFFFF_FFFC, 8'd1, 3'd2, 2'b01);
    model_read(32'hFFFF_FFFC, 1, 3'd2, 2'b01);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_d.size() <= i || rd_d[i] !== exp_d[i] || rd_r[i] !== exp_r[i])
        $display("FAIL wrap_beat%0d got d=%h resp=%0d exp d=%h resp=%0d", i, rd_d[i], rd_r[i], exp_d[i], exp_r[i]);
      else passes++;
    end
  endtask

  task automatic test_unsupported();
    drive_read(6'h0B, 32'h10, 8'd1, 3'd1, 2'b01);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rd_d.size() <= i || rd_d[i] !== 32'd0 || rd_r[i] !== 2'b10)
        $display("FAIL unsup_ar_beat%0d got d=%h resp=%0d exp d=0 resp=2", i, rd_d[i], rd_r[i]);
      else passes++;
    end
    wd[0] = 32'hBAD0_0000; wd[1] = 32'hBAD0_0001; ws[0] = 4'hF; ws[1] = 4'hF;
    drive_write(6'h0C, 32'h0, 8'd1, 3'd2, 2'b10);
    checks++;
    if (got_bresp !== model_write(32'h0, 1, 3'd2, 2'b10)) $display("FAIL unsup_aw_bresp got=%0d exp=2", got_bresp);
    else passes++;
    drive_read(6'h0D, 32'h0, 8'd1, 3'd2, 2'b01);
    model_read(32'h0, 1, 3'd2, 2'b01);
    checks++;
    if (rd_d.size() != 2 || rd_d[0] !== exp_d[0] || rd_d[1] !== exp_d[1])
      $display("FAIL unsup_mem_unchanged got %h %h exp %h %h", rd_d[0], rd_d[1], exp_d[0], exp_d[1]);
    else passes++;
  endtask

  task automatic test_fixed();
    wd[0] = 32'hC0DE_0001; wd[1] = 32'hC0DE_0002; wd[2] = 32'hC0DE_0003;
    ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'h6;
    drive_write(6'h11, 32'h20, 8'd2, 3'd2, 2'b00);
    checks++;
    if (got_bresp !== model_write(32'h20, 2, 3'd2, 2'b00)) $display("FAIL fixed_bresp got=%0d exp=0", got_bresp);
    else passes++;
    drive_read(6'h12, 32'h20, 8'd2, 3'd2, 2'b00);
    model_read(32'h20, 2, 3'd2, 2'b00);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rd_d.size() <= i || rd_d[i] !== exp_d[i] || rd_r[i] !== exp_r[i])
        $display("FAIL fixed_beat%0d got d=%h exp d=%h", i, rd_d[i], exp_d[i]);
      else passes++;
    end
  endtask

  task automatic test_wlast_mismatch();
    wd[0] = 32'h5; wd[1] = 32'h6; ws[0] = 4'hF; ws[1] = 4'hF;
    flip_last = 0;
    drive_write(6'h13, 32'h80, 8'd1, 3'd2, 2'b01);
    flip_last = -1;
    void'(model_write(32'h80, 1, 3'd2, 2'b01));
    checks++;
    if (got_bresp !== 2'b10 || b_valid !== 1'b0)
      $display("FAIL wlast_mismatch got resp=%0d b_vld_after=%0b exp resp=2 b_vld_after=0", got_bresp, b_valid);
    else passes++;
  endtask

  task automatic test_backpressure();
    int n;
    model_read(32'h10, 1, 3'd2, 2'b01);
    wd[0] = 32'h7777_8888; ws[0] = 4'hF;
    @(negedge clock);
    aw_valid = 1; aw_id = 6'h21; aw_addr = 32'h44; aw_len = 0; aw_size = 3'd2; aw_burst = 2'b01;
    n = 0; while (!aw_ready && n < 100) begin @(negedge clock); n++; end
    @(negedge clock); aw_valid = 0;
    w_valid = 1; w_data = wd[0]; w_strb = ws[0]; w_last = 1;
    @(negedge clock); w_valid = 0; w_last = 0;
    void'(model_write(32'h44, 0, 3'd2, 2'b01));
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (b_valid !== 1'b1 || b_id !== 6'h21 || b_resp !== 2'b00 || aw_ready !== 1'b0)
        $display("FAIL bp_b_hold cyc=%0d got vld=%0b id=%0h resp=%0d aw_rdy=%0b exp 1 21 0 0", c, b_valid, b_id, b_resp, aw_ready);
      else passes++;
      @(negedge clock);
    end
    b_ready = 1; @(negedge clock); b_ready = 0;
    ar_valid = 1; ar_id = 6'h22; ar_addr = 32'h10; ar_len = 1; ar_size = 3'd2; ar_burst = 2'b01;
    n = 0; while (!ar_ready && n < 100) begin @(negedge clock); n++; end
    @(negedge clock); ar_valid = 0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (r_valid !== 1'b1 || r_data !== exp_d[0] || r_resp !== 2'b00 || r_last !== 1'b0 || r_id !== 6'h22 || ar_ready !== 1'b0)
        $display("FAIL bp_r_hold cyc=%0d got vld=%0b d=%h last=%0b id=%0h ar_rdy=%0b exp 1 %h 0 22 0", c, r_valid, r_data, r_last, r_id, ar_ready, exp_d[0]);
      else passes++;
      @(negedge clock);
    end
    r_ready = 1; @(negedge clock);
    checks++;
    if (r_valid !== 1'b1 || r_data !== exp_d[1] || r_last !== 1'b1)
      $display("FAIL bp_r_beat1 got vld=%0b d=%h last=%0b exp 1 %h 1", r_valid, r_data, r_last, exp_d[1]);
    else passes++;
    @(negedge clock); r_ready = 0;
  endtask

  task automatic test_concurrent();
    int n;
    logic [31:0] old_val;
    old_val = model_mem[16];
    @(negedge clock);
    aw_valid = 1; aw_id = 6'h31; aw_addr = 32'h40; aw_len = 0; aw_size = 3'd2; aw_burst = 2'b01;
    n = 0; while (!aw_ready && n < 100) begin @(negedge clock); n++; end
    @(negedge clock); aw_valid = 0;
    w_valid = 1; w_data = 32'h0BAD_F00D; w_strb = 4'hF; w_last = 1;
    ar_valid = 1; ar_id = 6'h32; ar_addr = 32'h40; ar_len = 0; ar_size = 3'd2; ar_burst = 2'b01;
    checks++;
    if (w_ready !== 1'b1 || ar_ready !== 1'b1) $display("FAIL conc_setup got w_rdy=%0b ar_rdy=%0b exp 1 1", w_ready, ar_ready);
    else passes++;
    @(negedge clock);
    w_valid = 0; w_last = 0; ar_valid = 0;
    checks++;
    if (r_valid !== 1'b1 || r_data !== old_val) $display("FAIL conc_old_data got vld=%0b d=%h exp 1 %h", r_valid, r_data, old_val);
    else passes++;
    r_ready = 1; b_ready = 1;
    @(negedge clock); r_ready = 0; b_ready = 0;
    wd[0] = 32'h0BAD_F00D; ws[0] = 4'hF;
    void'(model_write(32'h40, 0, 3'd2, 2'b01));
    drive_read(6'h33, 32'h40, 8'd0, 3'd2, 2'b01);
    checks++;
    if (rd_d.size() != 1 || rd_d[0] !== model_mem[16]) $display("FAIL conc_new_data got d=%h exp %h", rd_d[0], model_mem[16]);
    else passes++;
  endtask

  task automatic test_random();
    logic [ID_W-1:0] id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst, eresp;
    for (int blk = 0; blk < DEPTH / 16; blk++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      drive_write(6'h3F, 32'(blk * 64), 8'd15, 3'd2, 2'b01);
      void'(model_write(32'(blk * 64), 15, 3'd2, 2'b01));
    end
    for (int k = 0; k < 30; k++) begin
      id = ID_W'($urandom); len = 8'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, DEPTH + 3)) * 32'd4 + 32'($urandom_range(0, 3));
      burst = 2'($urandom_range(0, 1));
      size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      if ($urandom_range(0, 9) == 0) burst = 2'($urandom_range(2, 3));
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      drive_write(id, addr, len, size, burst);
      eresp = model_write(addr, int'(len), size, burst);
      checks++;
      if (got_bresp !== eresp || got_bid !== id)
        $display("FAIL rand%0d_b got resp=%0d id=%0h exp resp=%0d id=%0h", k, got_bresp, got_bid, eresp, id);
      else passes++;
      drive_read(id ^ 6'h15, addr, len, 3'd2, burst[0] ? 2'b01 : 2'b00);
      model_read(addr, int'(len), 3'd2, burst[0] ? 2'b01 : 2'b00);
      for (int i = 0; i <= int'(len); i++) begin
        checks++;
        if (rd_d.size() <= i || rd_d[i] !== exp_d[i] || rd_r[i] !== exp_r[i] || rd_l[i] !== (i == int'(len)) || rd_id[i] !== (id ^ 6'h15))
          $display("FAIL rand%0d_beat%0d got d=%h resp=%0d last=%0b exp d=%h resp=%0d", k, i, rd_d[i], rd_r[i], rd_l[i], exp_d[i], exp_r[i]);
        else passes++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, seen, stray;
    @(negedge clock);
    ar_valid = 1; ar_id = 6'h05; ar_addr = 32'h0; ar_len = 8'd7; ar_size = 3'd2; ar_burst = 2'b01;
    n = 0; while (!ar_ready && n < 100) begin @(negedge clock); n++; end
    @(negedge clock); ar_valid = 0; r_ready = 1;
    seen = 0; n = 0;
    while (seen < 2 && n < 50) begin
      if (r_valid) seen++;
      @(negedge clock); n++;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (r_valid !== 1'b0 || ar_ready !== 1'b0 || seen != 2)
      $display("FAIL reset_mid_drop got r_vld=%0b ar_rdy=%0b beats_before=%0d exp 0 0 2", r_valid, ar_ready, seen);
    else passes++;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (ar_ready !== 1'b1 || aw_ready !== 1'b1) $display("FAIL reset_mid_ready got ar=%0b aw=%0b exp 1 1", ar_ready, aw_ready);
    else passes++;
    stray = 0;
    repeat (10) begin
      if (r_valid || b_valid) stray++;
      @(negedge clock);
    end
    r_ready = 0;
    checks++;
    if (stray != 0) $display("FAIL reset_mid_stray got=%0d exp=0", stray);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_strb();
    test_oob();
    test_unsupported();
    test_fixed();
    test_wlast_mismatch();
    test_wrap();
    test_backpressure();
    test_concurrent();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout after %0d of %0d checks", passes, checks);
    $fatal(1, "time limit");
  end

endmodule
